minmax_tracker: RTL and testbench
=================================

Name: minmax_tracker

Overview:
Downstream consumer of 4-bit magnitude comparison. It accepts a stream of unsigned samples over a valid/ready handshake and groups them into frames of FRAME_LEN samples. For each frame it tracks the running maximum, the running minimum, the index of the first maximum and the number of samples equal to the final maximum. It presents one result record per frame on an output valid/ready handshake and holds that record until it is taken.

Parameters:
DATA_W, 4, sample width in bits (unsigned).
FRAME_LEN, 8, samples per frame; legal range 1..256.
IDX_W, $clog2(FRAME_LEN) with minimum 1, width of the index and sample counter.
CNT_W, $clog2(FRAME_LEN+1), width of max_cnt.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort: discards the partial frame and returns to IDLE.
in_valid  input  1  in_data is valid.
in_ready  output  1  block accepts a sample this cycle.
in_data  input  DATA_W  sample.
out_valid  output  1  result record is valid.
out_ready  input  1  downstream takes the record.
max_val  output  DATA_W  frame maximum.
min_val  output  DATA_W  frame minimum.
max_idx  output  IDX_W  0-based position of the first occurrence of the maximum.
max_cnt  output  CNT_W  count of samples equal to max_val.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, max_val=0, min_val=0, max_idx=0, max_cnt=0, sample counter=0. Reset asserted mid-frame or mid-DONE clears everything immediately. There is no partial output.
- Accept: a sample is accepted when in_valid & in_ready at a rising edge of clk.
- FSM states: IDLE, ACCUM, DONE.
- IDLE (in_ready=1), on accept:
  - max=min=in_data, max_idx=0, max_cnt=1, counter=1.
  - Go to DONE if FRAME_LEN==1, else to ACCUM.
- ACCUM (in_ready=1), on accept of sample k (k = counter):
  - in_data > max: max=in_data, max_idx=k, max_cnt=1.
  - in_data == max: max_cnt+1, max_idx unchanged.
  - in_data < min: min=in_data.
  - counter+1. Go to DONE when k==FRAME_LEN-1.
  - No accept: hold all state.
- DONE (in_ready=0, out_valid=1):
  - Outputs are stable until out_valid & out_ready.
  - On that handshake go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
- Latency: out_valid rises the cycle after the last sample's handshake.
- Throughput: one sample per cycle within a frame, plus at least 1 dead cycle per frame (the DONE cycle).
- Simultaneous events:
  - In DONE, in_valid is ignored because in_ready=0. A new frame's first sample is accepted no earlier than the cycle after the output handshake.
  - clr has priority over any handshake in the same cycle. In DONE, clr drops the pending record (out_valid=0 next cycle).
  - clr in IDLE is a no-op.
- Comparison semantics: unsigned DATA_W-bit magnitude comparison with exactly one of gt/eq/lt true.
  - Maximum and minimum comparisons are independent and evaluated in the same cycle.
  - The first sample initialises both without comparison.
- Output registers: max_val/min_val/max_idx/max_cnt are the tracking registers themselves.
  - They show in-progress values during ACCUM.
  - Consumers sample them only when out_valid=1.
- Widths: max_cnt never exceeds FRAME_LEN. The counter never wraps within a frame; it resets to 0 on entry to IDLE.

Decomposition:
- Shared package: FSM state enum (IDLE, ACCUM, DONE) and a result-record struct {max_val, min_val, max_idx, max_cnt}. DATA_W is parameterised per instance.
- Sub-module mag_cmp: parameterised DATA_W unsigned comparator with outputs gt/eq/lt, purely combinational.
- Two instances: sample vs max, and sample vs min. FSM, counter and registers are in the top.

Test Plan:
- Frame 3,7,2,7,0,5,7,1 with in_valid continuous and out_ready=1 -> out_valid one cycle after the 8th accept; max=7, min=0, max_idx=1, max_cnt=3; in_ready=0 in that cycle.
- Frame 0,1,2,3,4,5,6,7 -> max=7, max_idx=7, max_cnt=1, min=0. Frame 9,9,9,9,9,9,9,9 -> max=min=9, max_idx=0, max_cnt=8.
- out_ready held 0 for 5 cycles after out_valid with in_valid=1 -> record stable, in_ready=0, no sample consumed. Release -> next frame starts the following cycle.
- Random in_valid gaps (~50% duty) on the frame 15,0,15,8,... -> results identical to the gap-free run.
- clr after 4 accepts, then frame 2,2,1,2,2,2,2,2 -> max=2, max_cnt=7, min=1, max_idx=0; the aborted samples have no effect.
- rst_n pulsed low asynchronously mid-ACCUM and again in DONE -> all outputs 0 and in_ready=1 immediately. FRAME_LEN=1 build: each accept yields out_valid next cycle with max_cnt=1.

Source files
------------

// File: rtl/minmax_tracker_pkg.sv
// Shared types for the frame min/max tracker: FSM state encoding, a
// width helper and the result-record layout of the default build.
package minmax_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index/counter width for a frame length; never below one bit so a
    // single-sample frame still has a legal vector.
    function automatic int idx_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_IDX_W     = idx_width(DEF_FRAME_LEN);
    localparam int DEF_CNT_W     = $clog2(DEF_FRAME_LEN + 1);

    // One per-frame result record at the default widths; instances built
    // with other parameters carry the same four fields at their own widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] max_val;
        logic [DEF_DATA_W-1:0] min_val;
        logic [DEF_IDX_W-1:0]  max_idx;
        logic [DEF_CNT_W-1:0]  max_cnt;
    } result_t;

endpackage

// File: rtl/minmax_tracker_mag_cmp.sv
// Unsigned magnitude comparator: exactly one of gt/eq/lt is high.
module mag_cmp #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_gt,
    output logic              o_eq,
    output logic              o_lt
);

    assign o_gt = (i_a >  i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/minmax_tracker.sv
// Frame min/max tracker: groups FRAME_LEN accepted samples into a frame,
// tracks max, min, first-max index and max multiplicity, and holds the
// record on a valid/ready output until it is taken.
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = idx_width(FRAME_LEN),
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [IDX_W-1:0]  max_idx,
    output logic [CNT_W-1:0]  max_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic [IDX_W-1:0]  r_max_idx;
    logic [CNT_W-1:0]  r_max_cnt;

    logic w_accept;
    logic w_last;
    logic w_max_gt, w_max_eq, w_max_lt;
    logic w_min_gt, w_min_eq, w_min_lt;

    // Max and min are compared independently in the same cycle.
    mag_cmp #(.DATA_W(DATA_W)) u_cmp_max (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_gt (w_max_gt),
        .o_eq (w_max_eq),
        .o_lt (w_max_lt)
    );

    mag_cmp #(.DATA_W(DATA_W)) u_cmp_min (
        .i_a  (in_data),
        .i_b  (r_min),
        .o_gt (w_min_gt),
        .o_eq (w_min_eq),
        .o_lt (w_min_lt)
    );

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == LAST_IDX);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; clr overrides any handshake.
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_state_nxt = (FRAME_LEN == 1) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clr) w_state_nxt = IDLE;
    end

    // Sample counter and tracking registers; counter returns to 0 whenever
    // the FSM heads back to IDLE, and holds on the last sample so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_max_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_state == DONE) begin
            if (out_ready) r_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_max     <= in_data;
                r_min     <= in_data;
                r_max_idx <= '0;
                r_max_cnt <= CNT_W'(1);
                r_cnt     <= IDX_W'(1);
            end else begin
                unique case ({w_max_gt, w_max_eq, w_max_lt})
                    3'b100: begin
                        r_max     <= in_data;
                        r_max_idx <= r_cnt;
                        r_max_cnt <= CNT_W'(1);
                    end
                    3'b010:  r_max_cnt <= r_max_cnt + CNT_W'(1);
                    3'b001:  ;
                    default: ;
                endcase
                unique case ({w_min_gt, w_min_eq, w_min_lt})
                    3'b001:          r_min <= in_data;
                    3'b100, 3'b010:  ;
                    default:         ;
                endcase
                if (!w_last) r_cnt <= r_cnt + IDX_W'(1);
            end
        end
    end

    assign max_val = r_max;
    assign min_val = r_min;
    assign max_idx = r_max_idx;
    assign max_cnt = r_max_cnt;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: default 8-sample build plus a
// single-sample build sharing clock and reset.
module tb_minmax_tracker;
    import minmax_tracker_pkg::*;

    typedef logic [3:0] frame_t [0:7];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, max_val, min_val, max_cnt;
    logic [2:0] max_idx;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, clr1;
    logic [3:0] in_data1, max_val1, min_val1;
    logic [0:0] max_idx1, max_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    minmax_tracker #(.DATA_W(4), .FRAME_LEN(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .max_cnt(max_cnt)
    );

    minmax_tracker #(.DATA_W(4), .FRAME_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .max_val(max_val1), .min_val(min_val1), .max_idx(max_idx1), .max_cnt(max_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one sample (optionally after a random idle cycle) and return
    // #1 after the edge that accepted it.
    task automatic push(input logic [3:0] d, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 20 && !in_ready; t++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Check the record the cycle after the last accept, then take it.
    task automatic expect_result(input string tag, input result_t exp);
        check({tag, ".out_valid"}, 32'(out_valid), 1);
        check({tag, ".in_ready"},  32'(in_ready), 0);
        check({tag, ".max_val"},   32'(max_val), 32'(exp.max_val));
        check({tag, ".min_val"},   32'(min_val), 32'(exp.min_val));
        check({tag, ".max_idx"},   32'(max_idx), 32'(exp.max_idx));
        check({tag, ".max_cnt"},   32'(max_cnt), 32'(exp.max_cnt));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".drop_valid"}, 32'(out_valid), 0);
        check({tag, ".rearm_ready"}, 32'(in_ready), 1);
    endtask

    task automatic run_frame(input string tag, input frame_t s, input bit gaps, input result_t exp);
        for (int i = 0; i < 8; i++) push(s[i], gaps);
        expect_result(tag, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"},  32'(in_ready), 1);
        check({tag, ".out_valid"}, 32'(out_valid), 0);
        check({tag, ".max_val"},   32'(max_val), 0);
        check({tag, ".min_val"},   32'(min_val), 0);
        check({tag, ".max_idx"},   32'(max_idx), 0);
        check({tag, ".max_cnt"},   32'(max_cnt), 0);
    endtask

    // Assert reset mid-cycle, check immediately, release away from an edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values({tag, ".after"});
    endtask

    frame_t fa, fb, fc, fd, fe, fh;

    initial begin
        fa = '{4'd3, 4'd7, 4'd2, 4'd7, 4'd0, 4'd5, 4'd7, 4'd1};
        fb = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        fc = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        fd = '{4'd15, 4'd0, 4'd15, 4'd8, 4'd3, 4'd15, 4'd0, 4'd7};
        fe = '{4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
        fh = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        clr1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        #3;
        check_reset_values("reset");
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frames, continuous in_valid, out_ready high.
        run_frame("frame_a", fa, 1'b0, '{4'd7, 4'd0, 3'd1, 4'd3});
        run_frame("ramp",    fb, 1'b0, '{4'd7, 4'd0, 3'd7, 4'd1});
        run_frame("flat9",   fc, 1'b0, '{4'd9, 4'd9, 3'd0, 4'd8});

        // Backpressure: record holds and nothing is consumed while in DONE.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(fh[i], 1'b0);
        in_valid = 1'b1;
        in_data  = 4'd5;
        for (int c = 0; c < 5; c++) begin
            check("hold.out_valid", 32'(out_valid), 1);
            check("hold.in_ready",  32'(in_ready), 0);
            check("hold.max_val",   32'(max_val), 8);
            check("hold.max_idx",   32'(max_idx), 7);
            check("hold.min_val",   32'(min_val), 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release.out_valid", 32'(out_valid), 0);
        check("release.in_ready",  32'(in_ready), 1);
        @(posedge clk); #1;
        check("release.first_max", 32'(max_val), 5);
        check("release.first_cnt", 32'(max_cnt), 1);
        in_valid = 1'b0;
        push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd6, 1'b0); push(4'd2, 1'b0);
        push(4'd3, 1'b0); push(4'd4, 1'b0); push(4'd0, 1'b0);
        expect_result("after_hold", '{4'd6, 4'd0, 3'd2, 4'd2});

        // Gap-free and gapped runs of the same frame must agree.
        run_frame("nogap", fd, 1'b0, '{4'd15, 4'd0, 3'd0, 4'd3});
        run_frame("gaps",  fd, 1'b1, '{4'd15, 4'd0, 3'd0, 4'd3});

        // clr mid-frame, colliding with a valid sample that must be dropped.
        push(4'd15, 1'b0); push(4'd15, 1'b0); push(4'd0, 1'b0); push(4'd15, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 4'd15;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        check("clr.in_ready",  32'(in_ready), 1);
        check("clr.out_valid", 32'(out_valid), 0);
        run_frame("post_clr", fe, 1'b0, '{4'd2, 4'd1, 3'd0, 4'd7});

        // clr in DONE drops the pending record even with out_ready high.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(fc[i], 1'b0);
        check("clr_done.pending", 32'(out_valid), 1);
        clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_done.out_valid", 32'(out_valid), 0);
        check("clr_done.in_ready",  32'(in_ready), 1);
        run_frame("post_clr_done", fb, 1'b0, '{4'd7, 4'd0, 3'd7, 4'd1});

        // Asynchronous reset mid-ACCUM and in DONE.
        push(4'd9, 1'b0); push(4'd9, 1'b0); push(4'd9, 1'b0);
        pulse_reset("rst_accum");
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(fa[i], 1'b0);
        check("rst_done.pending", 32'(out_valid), 1);
        pulse_reset("rst_done");
        out_ready = 1'b1;
        run_frame("post_rst", fa, 1'b0, '{4'd7, 4'd0, 3'd1, 4'd3});

        // Single-sample frames: each accept completes a frame.
        for (int k = 0; k < 2; k++) begin
            in_valid1 = 1'b1;
            in_data1  = (k == 0) ? 4'd9 : 4'd4;
            check("len1.in_ready", 32'(in_ready1), 1);
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            check("len1.out_valid", 32'(out_valid1), 1);
            check("len1.in_ready_done", 32'(in_ready1), 0);
            check("len1.max_cnt", 32'(max_cnt1), 1);
            check("len1.max_val", 32'(max_val1), (k == 0) ? 9 : 4);
            check("len1.min_val", 32'(min_val1), (k == 0) ? 9 : 4);
            check("len1.max_idx", 32'(max_idx1), 0);
            @(posedge clk); #1;
            check("len1.drop", 32'(out_valid1), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
